operator_slot_sequencer: RTL
============================

OPERATOR_SLOT_SEQUENCER -- requirements
Module: operator_slot_sequencer

Interface
REQ-001 SHALL have parameter NUM_BANKS, default 2, number of 18-operator banks (1..2).
REQ-002 SHALL have parameter SLOT_CYCLES, default 2, clock cycles per operator slot (>=1).
REQ-003 SHALL have parameter PIPELINE_DELAY, default 6, operator latency from slot_en to op_out_valid.
REQ-004 SHALL have parameter OP_OUT_WIDTH, default 13, signed operator output width.
REQ-005 SHALL have port clk  in  1  sole clock.
REQ-006 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port sample_clk_en  in  1  one-cycle sample-start pulse.
REQ-008 SHALL have port ryt  in  1  rhythm mode (bank 0 only).
REQ-009 SHALL have port cnt  in  NUM_BANKS*9  per-channel connection bit (1 = additive).
REQ-010 SHALL have port conn4  in  NUM_BANKS*3  4-op enable for channel pairs (c, c+3), c=0..2 per bank.
REQ-011 SHALL have ports op_out_valid  in  1, op_out_bank  in  1, op_out_num  in  5, op_out  in  OP_OUT_WIDTH: operator pipeline result.
REQ-012 SHALL have ports slot_en  out  1, slot_bank  out  1, slot_op  out  5: current slot issue.
REQ-013 SHALL have port slot_mod  out  OP_OUT_WIDTH  signed modulation for issued slot.
REQ-014 SHALL have port slot_use_fb  out  1  feedback enable for issued slot.
REQ-015 SHALL have ports busy  out  1, ops_done_pulse  out  1, sample_overrun  out  1.

Function
REQ-016 SHALL implement FSM IDLE/RUN with slot counter (0..NUM_BANKS*18-1) and cycle counter (0..SLOT_CYCLES-1).
REQ-017 SHALL go IDLE->RUN on sample_clk_en; first slot_en asserted in the following cycle (bank 0, op 0).
REQ-018 SHALL assert slot_en for exactly the first cycle of each slot; slot_bank/slot_op valid with slot_en and held through the slot.
REQ-019 SHALL order slots bank 0 ops 0..17, then bank 1 ops 0..17; RUN->IDLE after last cycle of last slot.
REQ-020 SHALL hold busy high in RUN, low in IDLE.
REQ-021 SHALL ignore sample_clk_en in RUN and pulse sample_overrun one cycle later; sequence not restarted.
REQ-022 SHALL define channel ch = 3*(op/6) + (op%3), modulator if op%6<3, carrier otherwise.
REQ-023 SHALL keep a modulation buffer of NUM_BANKS*9 entries; on op_out_valid write op_out into entry of its channel if modulator, or if carrier of first channel of an enabled 4-op pair.
REQ-024 SHALL drive slot_mod registered, valid from slot_en+1 until next slot_en+1.
REQ-025 SHALL set slot_mod = 0 for modulators, except modulator of second channel of enabled 4-op pair: buffered carrier of first channel, 0 if cnt of first channel = 1.
REQ-026 SHALL set slot_mod for carriers = buffered modulator of same channel, 0 if cnt[ch] = 1.
REQ-027 SHALL force slot_mod = 0 for bank 0 ops 16,17 when ryt = 1.
REQ-028 SHALL bypass op_out into slot_mod when op_out_valid coincides with the slot_en cycle needing that entry.
REQ-029 SHALL require PIPELINE_DELAY <= 3*SLOT_CYCLES (elaboration-time check, fatal otherwise).
REQ-030 SHALL drive slot_use_fb registered with slot_en: 1 for modulators, 0 for carriers, 0 for bank 0 ops 13,14 when ryt = 1, 0 for second-channel modulator of enabled 4-op pair.
REQ-031 SHALL pulse ops_done_pulse one cycle after op_out_valid with bank NUM_BANKS-1, op 17.
REQ-032 SHALL sample ryt, cnt, conn4 at slot_en of the slot using them; mid-sample changes affect only later slots.
REQ-033 SHALL ignore op_out_valid with bank >= NUM_BANKS or op > 17.

Reset
REQ-034 SHALL on reset low immediately force IDLE, counters 0, all outputs 0, buffer cleared, regardless of state.
REQ-035 SHALL resume only on sample_clk_en after reset release; no slot_en in first cycle after release.

Verification
REQ-036 Defaults, sample_clk_en pulse -> 36 slot_en pulses spaced 2 cycles, first 1 cycle after, busy high 72 cycles.
REQ-037 cnt[0]=0, op 0 out = 0x0123 at cycle 6 -> op 3 slot_mod = 0x0123 (via bypass); cnt[0]=1 -> 0.
REQ-038 conn4[0]=1, cnt[0]=0, op 3 out = -5 -> op 6 slot_mod = -5, slot_use_fb = 0.
REQ-039 ryt=1 -> bank 0 ops 16,17 slot_mod 0; ops 13,14 slot_use_fb 0.
REQ-040 sample_clk_en at slot 10 -> sample_overrun pulse, sequence completes normally, ops_done_pulse once.
REQ-041 reset low at slot 20 -> outputs 0, busy 0 same cycle; next sample starts at bank 0 op 0 with slot_mod 0.

Source files
------------

// File: rtl/operator_slot_sequencer.sv
// Operator slot sequencer: walks NUM_BANKS x 18 operator slots per sample and hands each
// issued slot its modulation input and feedback enable.
module operator_slot_sequencer #(
    parameter int unsigned NUM_BANKS      = 2,
    parameter int unsigned SLOT_CYCLES    = 2,
    parameter int unsigned PIPELINE_DELAY = 6,
    parameter int unsigned OP_OUT_WIDTH   = 13
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           sample_clk_en,
    input  logic                           ryt,
    input  logic [NUM_BANKS*9-1:0]         cnt,
    input  logic [NUM_BANKS*3-1:0]         conn4,
    input  logic                           op_out_valid,
    input  logic                           op_out_bank,
    input  logic [4:0]                     op_out_num,
    input  logic signed [OP_OUT_WIDTH-1:0] op_out,
    output logic                           slot_en,
    output logic                           slot_bank,
    output logic [4:0]                     slot_op,
    output logic signed [OP_OUT_WIDTH-1:0] slot_mod,
    output logic                           slot_use_fb,
    output logic                           busy,
    output logic                           ops_done_pulse,
    output logic                           sample_overrun
);
    localparam int unsigned     NUM_CH      = NUM_BANKS * 9;
    localparam int unsigned     CYC_W       = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam logic [CYC_W-1:0] LAST_CYC   = CYC_W'(SLOT_CYCLES - 1);
    localparam logic            LAST_BANK   = 1'(NUM_BANKS - 1);
    localparam logic            SINGLE_BANK = (NUM_BANKS == 1);

    // A result must land in the buffer before the carrier three slots later reads it.
    if (PIPELINE_DELAY > 3 * SLOT_CYCLES) begin : g_bad_delay
        $fatal(1, "PIPELINE_DELAY exceeds 3*SLOT_CYCLES");
    end
    if (NUM_BANKS == 0 || NUM_BANKS > 2) begin : g_bad_banks
        $fatal(1, "NUM_BANKS must be 1 or 2");
    end

    typedef enum logic {StIdle, StRun} state_e;

    function automatic logic [3:0] chan_of(input logic [4:0] op);
        logic [4:0] grp;
        logic [4:0] sub;
        grp = op / 5'd6;
        sub = op % 5'd3;
        return 4'(grp * 5'd3 + sub);
    endfunction

    function automatic logic is_mod(input logic [4:0] op);
        return (op % 5'd6) < 5'd3;
    endfunction

    state_e               state, state_next;
    logic                 bank_cnt, bank_next;
    logic [4:0]           op_cnt, op_next;
    logic [CYC_W-1:0]     cyc_cnt, cyc_next;
    logic signed [OP_OUT_WIDTH-1:0] mod_buf [NUM_CH];

    logic                 launch, fb_next;
    logic [3:0]           nx_ch, rd_ch, wr_ch;
    logic [2:0]           nx_pair, rd_pair;
    logic                 rd_need, wr_ok, wr_en;
    logic [4:0]           rd_idx, wr_idx;
    logic signed [OP_OUT_WIDTH-1:0] mod_sel;

    assign busy      = (state == StRun);
    assign slot_en   = busy && (cyc_cnt == '0);
    assign slot_bank = bank_cnt;
    assign slot_op   = op_cnt;

    always_comb begin
        state_next = state;
        bank_next  = bank_cnt;
        op_next    = op_cnt;
        cyc_next   = cyc_cnt;
        if (state == StIdle) begin
            if (sample_clk_en) begin
                state_next = StRun;
                bank_next  = 1'b0;
                op_next    = '0;
                cyc_next   = '0;
            end
        end else if (cyc_cnt == LAST_CYC) begin
            cyc_next = '0;
            if (op_cnt == 5'd17) begin
                op_next = '0;
                if (bank_cnt == LAST_BANK) begin
                    state_next = StIdle;
                    bank_next  = 1'b0;
                end else begin
                    bank_next = 1'b1;
                end
            end else begin
                op_next = op_cnt + 5'd1;
            end
        end else begin
            cyc_next = cyc_cnt + CYC_W'(1);
        end
    end

    // Feedback enable is loaded on the edge that opens the slot so it lines up with slot_en.
    always_comb begin
        launch  = (state_next == StRun) && (cyc_next == '0);
        nx_ch   = chan_of(op_next);
        nx_pair = (bank_next ? 3'd3 : 3'd0) + 3'(nx_ch - 4'd3);
        fb_next = is_mod(op_next);
        if (ryt && !bank_next && (op_next == 5'd13 || op_next == 5'd14)) begin
            fb_next = 1'b0;
        end
        if (nx_ch >= 4'd3 && nx_ch <= 4'd5 && conn4[nx_pair]) begin
            fb_next = 1'b0;
        end
    end

    always_comb begin
        wr_ch  = chan_of(op_out_num);
        wr_idx = (op_out_bank ? 5'd9 : 5'd0) + 5'(wr_ch);
        wr_ok  = op_out_valid && !(SINGLE_BANK && op_out_bank) && (op_out_num <= 5'd17);
        wr_en  = wr_ok && (is_mod(op_out_num) ||
                 (wr_ch <= 4'd2 && conn4[(op_out_bank ? 3'd3 : 3'd0) + 3'(wr_ch)]));
    end

    // Modulators of a 4-op second channel read the first channel's carrier entry.
    always_comb begin
        rd_ch   = chan_of(op_cnt);
        rd_pair = (bank_cnt ? 3'd3 : 3'd0) + 3'(rd_ch - 4'd3);
        rd_idx  = (bank_cnt ? 5'd9 : 5'd0) + 5'(rd_ch);
        rd_need = 1'b0;
        if (!is_mod(op_cnt)) begin
            rd_need = 1'b1;
        end else if (rd_ch >= 4'd3 && rd_ch <= 4'd5 && conn4[rd_pair]) begin
            rd_need = 1'b1;
            rd_idx  = rd_idx - 5'd3;
        end
        mod_sel = '0;
        if (rd_need && !cnt[rd_idx] && !(ryt && !bank_cnt && op_cnt >= 5'd16)) begin
            mod_sel = (wr_en && wr_idx == rd_idx) ? op_out : mod_buf[rd_idx];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= StIdle;
            bank_cnt       <= 1'b0;
            op_cnt         <= '0;
            cyc_cnt        <= '0;
            slot_mod       <= '0;
            slot_use_fb    <= 1'b0;
            ops_done_pulse <= 1'b0;
            sample_overrun <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                mod_buf[i] <= '0;
            end
        end else begin
            state          <= state_next;
            bank_cnt       <= bank_next;
            op_cnt         <= op_next;
            cyc_cnt        <= cyc_next;
            ops_done_pulse <= wr_ok && (op_out_bank == LAST_BANK) && (op_out_num == 5'd17);
            sample_overrun <= busy && sample_clk_en;
            if (wr_en) begin
                mod_buf[wr_idx] <= op_out;
            end
            if (slot_en) begin
                slot_mod <= mod_sel;
            end
            if (launch) begin
                slot_use_fb <= fb_next;
            end
        end
    end

endmodule
